acc_writeback: RTL and testbench

Drains one 8x8 accumulator tile into the scratchpad RAM as a stream of single-word write requests. It sits between the `accumulator` output (`res_out`) and the RAM write port. It is the write-side counterpart of the `fsm` read path, which pulls operands out of the same RAM. On `start` it snapshots the tile and writes the valid M x N sub-block row-major from a base address. It honours a per-cycle write grant so the RAM port can be shared with the read path.

---
 rtl/acc_wb_pkg.sv | 25 ++
 rtl/wb_index_counter.sv | 51 +++++
 rtl/acc_writeback.sv | 126 ++++++++++++
 tb/tb_acc_writeback.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/acc_wb_pkg.sv
// Shared types and constants for the accumulator-tile writeback path.
// The tile is always TILE_DIM x TILE_DIM, stored row-major in the flat accumulator bus.
package acc_wb_pkg;

    localparam int TILE_DIM   = 8;
    localparam int TILE_ELEMS = TILE_DIM * TILE_DIM;
    // A clamped dimension ranges over 0..TILE_DIM, so it needs one bit more than a position.
    localparam int DIM_W      = 4;
    localparam int POS_W      = 3;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DONE
    } wb_state_e;

    function automatic int unsigned elem_offset(
        input int unsigned r,
        input int unsigned c,
        input int unsigned width
    );
        return (r * TILE_DIM + c) * width;
    endfunction

endpackage

// File: rtl/wb_index_counter.sv
// Row/column walker over the valid M x N sub-block of a tile, row-major.
// Exposes the position the walk moves to on the next advance and flags the final element.
module wb_index_counter
    import acc_wb_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [DIM_W-1:0] m_lim,
    input  logic [DIM_W-1:0] n_lim,
    input  logic             advance,
    output logic [POS_W-1:0] row_next,
    output logic [POS_W-1:0] col_next,
    output logic             last
);

    logic [DIM_W-1:0] m_reg;
    logic [DIM_W-1:0] n_reg;
    logic [POS_W-1:0] row_reg;
    logic [POS_W-1:0] col_reg;
    logic             col_wrap;

    always_comb begin
        col_wrap = ({1'b0, col_reg} == n_reg - DIM_W'(1));
        last     = col_wrap && ({1'b0, row_reg} == m_reg - DIM_W'(1));
        row_next = row_reg;
        col_next = col_reg + POS_W'(1);
        if (col_wrap) begin
            col_next = '0;
            row_next = row_reg + POS_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_reg   <= '0;
            n_reg   <= '0;
            row_reg <= '0;
            col_reg <= '0;
        end else if (load) begin
            m_reg   <= m_lim;
            n_reg   <= n_lim;
            row_reg <= '0;
            col_reg <= '0;
        end else if (advance) begin
            row_reg <= row_next;
            col_reg <= col_next;
        end
    end

endmodule

// File: rtl/acc_writeback.sv
// Drains a snapshot of one 8x8 accumulator tile into RAM as single-word writes,
// packing the valid M x N sub-block row-major from a base address under a per-cycle grant.
module acc_writeback
    import acc_wb_pkg::*;
#(
    parameter int PE_OUT_WIDTH   = 32,
    parameter int RAM_DATA_WIDTH = 32,
    parameter int ADDR_WIDTH     = 12,
    parameter int INDEX_WIDTH    = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic [ADDR_WIDTH-1:0]            base_addr,
    input  logic [INDEX_WIDTH-1:0]           M,
    input  logic [INDEX_WIDTH-1:0]           N,
    input  logic [TILE_ELEMS*PE_OUT_WIDTH-1:0] acc_in,
    input  logic                             write_grant,
    output logic                             write_req,
    output logic [ADDR_WIDTH-1:0]            write_addr,
    output logic [RAM_DATA_WIDTH-1:0]        write_data,
    output logic                             busy,
    output logic                             done
);

    wb_state_e               state_reg;
    logic [PE_OUT_WIDTH-1:0] snapshot [TILE_ELEMS];
    logic [DIM_W-1:0]        m_lim;
    logic [DIM_W-1:0]        n_lim;
    logic                    capture;
    logic                    accept;
    logic [POS_W-1:0]        row_next;
    logic [POS_W-1:0]        col_next;
    logic                    last;

    function automatic logic [RAM_DATA_WIDTH-1:0] sext(input logic [PE_OUT_WIDTH-1:0] e);
        logic signed [RAM_DATA_WIDTH-1:0] w;
        w = $signed(e);
        return w;
    endfunction

    assign m_lim   = (M > INDEX_WIDTH'(TILE_DIM)) ? DIM_W'(TILE_DIM) : DIM_W'(M);
    assign n_lim   = (N > INDEX_WIDTH'(TILE_DIM)) ? DIM_W'(TILE_DIM) : DIM_W'(N);
    assign capture = (state_reg == IDLE) && start;
    assign accept  = write_req && write_grant;

    wb_index_counter u_index (
        .clk      (clk),
        .reset    (reset),
        .load     (capture),
        .m_lim    (m_lim),
        .n_lim    (n_lim),
        .advance  (accept),
        .row_next (row_next),
        .col_next (col_next),
        .last     (last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < TILE_ELEMS; i++) begin
                snapshot[i] <= '0;
            end
        end else if (capture) begin
            for (int i = 0; i < TILE_ELEMS; i++) begin
                snapshot[i] <= acc_in[elem_offset(i / TILE_DIM, i % TILE_DIM, PE_OUT_WIDTH) +: PE_OUT_WIDTH];
            end
        end
    end

    // write_addr doubles as the running address counter; it wraps modulo 2^ADDR_WIDTH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= IDLE;
            write_req  <= 1'b0;
            write_addr <= '0;
            write_data <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        write_addr <= base_addr;
                        busy       <= 1'b1;
                        if (m_lim == '0 || n_lim == '0) begin
                            state_reg <= DONE;
                            write_req <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            state_reg  <= WRITE;
                            write_req  <= 1'b1;
                            // The snapshot is loading on this same edge, so take (0,0) from the bus.
                            write_data <= sext(acc_in[elem_offset(0, 0, PE_OUT_WIDTH) +: PE_OUT_WIDTH]);
                        end
                    end
                end
                WRITE: begin
                    if (accept) begin
                        write_addr <= write_addr + ADDR_WIDTH'(1);
                        if (last) begin
                            state_reg <= DONE;
                            write_req <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            write_data <= sext(snapshot[{row_next, col_next}]);
                        end
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    write_req <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_acc_writeback.sv
// Randomized and directed drains of acc_writeback checked against a queue-based reference
// that lists the expected (address, data) writes straight from the tile, M, N and base.
module tb_acc_writeback;

    localparam int PW = 16;
    localparam int RW = 32;
    localparam int AW = 12;
    localparam int IW = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [AW-1:0]     base_addr;
    logic [IW-1:0]     M;
    logic [IW-1:0]     N;
    logic [64*PW-1:0]  acc_in;
    logic              write_grant;
    logic              write_req;
    logic [AW-1:0]     write_addr;
    logic [RW-1:0]     write_data;
    logic              busy;
    logic              done;

    int n_cmp = 0;
    int n_bad = 0;
    logic [PW-1:0] tile [64];

    always #5 clk = ~clk;

    acc_writeback #(
        .PE_OUT_WIDTH   (PW),
        .RAM_DATA_WIDTH (RW),
        .ADDR_WIDTH     (AW),
        .INDEX_WIDTH    (IW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .base_addr   (base_addr),
        .M           (M),
        .N           (N),
        .acc_in      (acc_in),
        .write_grant (write_grant),
        .write_req   (write_req),
        .write_addr  (write_addr),
        .write_data  (write_data),
        .busy        (busy),
        .done        (done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req"},  64'(write_req),  64'd0);
        check({tag, "_addr"}, 64'(write_addr), 64'd0);
        check({tag, "_data"}, 64'(write_data), 64'd0);
        check({tag, "_busy"}, 64'(busy),       64'd0);
        check({tag, "_done"}, 64'(done),       64'd0);
    endtask

    task automatic drive_tile();
        for (int i = 0; i < 64; i++) acc_in[i*PW +: PW] = tile[i];
    endtask

    task automatic scramble_bus();
        for (int i = 0; i < 64; i++) acc_in[i*PW +: PW] = PW'($urandom);
    endtask

    // gmode: 0 = grant always, 1 = repeating 1,0,0,1, 2 = random grant.
    // abort_after > 0 pulls reset low once that many writes have been accepted.
    task automatic drain(input logic [AW-1:0] base, input int m, input int n,
                         input int gmode, input int abort_after);
        logic [AW-1:0] qa[$];
        logic [RW-1:0] qd[$];
        int mc, nc, k, acc, stalls;
        logic g;
        logic [PW-1:0] e;
        mc = (m > 8) ? 8 : m;
        nc = (n > 8) ? 8 : n;
        for (int r = 0; r < mc; r++) begin
            for (int c = 0; c < nc; c++) begin
                e = tile[r*8 + c];
                qa.push_back(AW'(int'(base) + r*nc + c));
                qd.push_back({{(RW-PW){e[PW-1]}}, e});
            end
        end

        @(negedge clk);
        start       = 1'b1;
        base_addr   = base;
        M           = IW'(m);
        N           = IW'(n);
        write_grant = 1'($urandom);
        drive_tile();
        @(negedge clk);
        k = 1; acc = 0; stalls = 0;
        start = 1'($urandom);
        scramble_bus();

        while (qa.size() > 0) begin
            check("busy",  64'(busy),       64'd1);
            check("req",   64'(write_req),  64'd1);
            check("addr",  64'(write_addr), 64'(qa[0]));
            check("data",  64'(write_data), 64'(qd[0]));
            check("done_early", 64'(done),  64'd0);
            if (abort_after > 0 && acc == abort_after) begin
                reset = 1'b0;
                #1;
                check_all_zero("abort");
                @(negedge clk);
                start = 1'b0;
                reset = 1'b1;
                $display("drain base=0x%03h M=%0d N=%0d aborted after %0d writes", base, m, n, acc);
                return;
            end
            case (gmode)
                0:       g = 1'b1;
                1:       g = ((k - 1) % 4 == 0) || ((k - 1) % 4 == 3);
                default: g = ($urandom_range(0, 3) != 0);
            endcase
            write_grant = g;
            start = 1'($urandom);
            scramble_bus();
            if (g) begin
                void'(qa.pop_front());
                void'(qd.pop_front());
                acc++;
            end else begin
                stalls++;
            end
            @(negedge clk);
            k++;
            if (k > 1000) begin
                check("timeout", 64'd1, 64'd0);
                return;
            end
        end

        check("done",       64'(done),      64'd1);
        check("busy_done",  64'(busy),      64'd1);
        check("req_done",   64'(write_req), 64'd0);
        check("done_cycle", 64'(k),         64'(mc*nc + stalls + 1));
        start       = 1'b0;
        write_grant = 1'($urandom);
        @(negedge clk);
        check("done_clear", 64'(done),      64'd0);
        check("busy_clear", 64'(busy),      64'd0);
        check("req_idle",   64'(write_req), 64'd0);
        $display("drain base=0x%03h M=%0d N=%0d writes=%0d stalls=%0d done_cycle=%0d",
                 base, m, n, acc, stalls, k);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; write_grant = 1'b0;
        base_addr = '0; M = '0; N = '0; acc_in = '0;
        #1;
        check_all_zero("reset");
        #20;
        @(negedge clk);
        reset = 1'b1;

        // Full tile with element (r,c) = r*8+c+1.
        for (int i = 0; i < 64; i++) tile[i] = PW'(i + 1);
        drain(12'h100, 8, 8, 0, 0);
        drain(12'h000, 3, 5, 0, 0);
        drain(12'h040, 2, 2, 1, 0);
        drain(12'hFFE, 2, 2, 0, 0);
        drain(12'h200, 0, 8, 0, 0);
        drain(12'h200, 8, 0, 2, 0);
        drain(12'h010, 12, 9, 2, 0);

        // Negative element must sign-extend to the full word.
        tile[0] = '1;
        drain(12'h300, 1, 1, 0, 0);

        // Abort mid-drain, then a fresh drain must restart from (0,0).
        for (int i = 0; i < 64; i++) tile[i] = PW'($urandom);
        drain(12'h080, 8, 8, 0, 10);
        check_all_zero("post_abort");
        drain(12'h080, 8, 8, 2, 0);

        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < 64; i++) tile[i] = PW'($urandom);
            drain(AW'($urandom), $urandom_range(0, 10), $urandom_range(0, 10), 2, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
